// File: rtl/fb_stream_reader_pkg.sv
// Shared constants for the frame-buffer stream reader: pixel field widths,
// default image geometry and the reader state encoding.
`timescale 1ns/1ps
package fb_stream_reader_pkg;

  localparam int c_r444_w   = 4;
  localparam int c_g444_w   = 4;
  localparam int c_b444_w   = 4;
  localparam int c_r565_w   = 5;
  localparam int c_g565_w   = 6;
  localparam int c_b565_w   = 5;
  localparam int c_rgb444_w = c_r444_w + c_g444_w + c_b444_w;
  localparam int c_rgb565_w = c_r565_w + c_g565_w + c_b565_w;

  localparam int c_def_img_cols     = 80;
  localparam int c_def_img_rows     = 60;
  localparam int c_def_nb_img_pxls  = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } fsr_state_e;

endpackage

// File: rtl/fb_stream_reader_rgb444_to_rgb565.sv
// RGB444 to RGB565 expansion by MSB replication; output channel order is
// selectable so the same block serves panels with swapped red/blue.
`timescale 1ns/1ps
module rgb444_to_rgb565 import fb_stream_reader_pkg::*; #(
  parameter bit c_swap_r_b = 1'b1
) (
  input  logic [c_rgb444_w-1:0] rgb444,
  output logic [c_rgb565_w-1:0] rgb565
);

  logic [c_r565_w-1:0] r5_s;
  logic [c_g565_w-1:0] g6_s;
  logic [c_b565_w-1:0] b5_s;

  // Widen each channel by repeating its top bits, then pack.
  always_comb begin
    r5_s = {rgb444[11:8], rgb444[11]};
    g6_s = {rgb444[7:4], rgb444[7:6]};
    b5_s = {rgb444[3:0], rgb444[3]};
    if (c_swap_r_b) begin
      rgb565 = {b5_s, g6_s, r5_s};
    end else begin
      rgb565 = {r5_s, g6_s, b5_s};
    end
  end

endmodule

// File: rtl/fb_stream_reader.sv
// Scans the frame buffer once per frame request and streams RGB565 pixels
// into the video FIFO, holding one pixel in a skid register under backpressure.
`timescale 1ns/1ps
module fb_stream_reader import fb_stream_reader_pkg::*; #(
  parameter int c_img_cols    = c_def_img_cols,
  parameter int c_img_rows    = c_def_img_rows,
  parameter int c_img_pxls    = c_img_cols * c_img_rows,
  parameter int c_nb_img_pxls = c_def_nb_img_pxls,
  parameter int c_nb_buf      = c_rgb444_w,
  parameter bit c_swap_r_b    = 1'b1,
  parameter bit c_continuous  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     frame_sync,
  output logic [c_nb_img_pxls-1:0] fb_addr,
  input  logic [c_nb_buf-1:0]      fb_data,
  input  logic                     fifo_wfull,
  input  logic                     fifo_awfull,
  output logic                     fifo_winc,
  output logic [15:0]              fifo_wdata,
  output logic                     busy,
  output logic                     frame_done,
  output logic [7:0]               frames_cnt
);

  localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_img_pxls - 1);

  fsr_state_e                 state_r, state_next_s;
  logic [c_nb_img_pxls-1:0]   addr_next_s;
  logic                       busy_next_s;
  logic                       done_s;
  logic                       rd_req_s;
  logic                       rd_valid_r;
  logic                       sync_d_r;
  logic                       sync_rise_s;
  logic                       pending_r, pending_next_s;
  logic                       skid_full_r;
  logic [15:0]                skid_data_r;
  logic [15:0]                pix_s;

  rgb444_to_rgb565 #(.c_swap_r_b(c_swap_r_b)) u_conv (
    .rgb444 (fb_data),
    .rgb565 (pix_s)
  );

  assign sync_rise_s = c_continuous & frame_sync & ~sync_d_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state, read issue and frame bookkeeping decisions.
  always_comb begin
    state_next_s   = state_r;
    addr_next_s    = fb_addr;
    busy_next_s    = busy;
    done_s         = 1'b0;
    rd_req_s       = 1'b0;
    pending_next_s = pending_r;
    case (state_r)
      ST_IDLE: begin
        if (start || sync_rise_s) begin
          state_next_s   = ST_READ;
          addr_next_s    = '0;
          busy_next_s    = 1'b1;
          pending_next_s = 1'b0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (sync_rise_s) begin
          pending_next_s = 1'b1;
        end else begin
          pending_next_s = pending_r;
        end
        // Never issue when the FIFO or the skid could not absorb the result.
        if (!fifo_awfull && !skid_full_r) begin
          rd_req_s = 1'b1;
          if (fb_addr == c_last_addr) begin
            addr_next_s  = '0;
            state_next_s = ST_DRAIN;
          end else begin
            addr_next_s = fb_addr + c_nb_img_pxls'(1);
          end
        end else begin
          rd_req_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (sync_rise_s) begin
          pending_next_s = 1'b1;
        end else begin
          pending_next_s = pending_r;
        end
        if (!rd_valid_r && !skid_full_r) begin
          done_s = 1'b1;
          if (pending_next_s) begin
            state_next_s   = ST_READ;
            addr_next_s    = '0;
            busy_next_s    = 1'b1;
            pending_next_s = 1'b0;
          end else begin
            state_next_s = ST_IDLE;
            busy_next_s  = 1'b0;
          end
        end else begin
          done_s = 1'b0;
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        addr_next_s    = '0;
        busy_next_s    = 1'b0;
        pending_next_s = 1'b0;
      end
    endcase
  end

  // Address, read-valid pipeline and frame status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_addr    <= '0;
      rd_valid_r <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frames_cnt <= 8'd0;
      pending_r  <= 1'b0;
      sync_d_r   <= 1'b0;
    end else begin
      fb_addr    <= addr_next_s;
      rd_valid_r <= rd_req_s;
      busy       <= busy_next_s;
      frame_done <= done_s;
      pending_r  <= pending_next_s;
      sync_d_r   <= frame_sync;
      if (done_s) begin
        frames_cnt <= frames_cnt + 8'd1;
      end else begin
        frames_cnt <= frames_cnt;
      end
    end
  end

  // FIFO write path; a held skid pixel always goes out before fresh data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_winc   <= 1'b0;
      fifo_wdata  <= 16'h0000;
      skid_full_r <= 1'b0;
      skid_data_r <= 16'h0000;
    end else begin
      if (skid_full_r && !fifo_wfull) begin
        fifo_winc   <= 1'b1;
        fifo_wdata  <= skid_data_r;
        skid_full_r <= rd_valid_r;
        if (rd_valid_r) begin
          skid_data_r <= pix_s;
        end else begin
          skid_data_r <= skid_data_r;
        end
      end else if (skid_full_r) begin
        fifo_winc <= 1'b0;
      end else if (rd_valid_r && !fifo_wfull) begin
        fifo_winc  <= 1'b1;
        fifo_wdata <= pix_s;
      end else if (rd_valid_r) begin
        fifo_winc   <= 1'b0;
        skid_full_r <= 1'b1;
        skid_data_r <= pix_s;
      end else begin
        fifo_winc <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_stream_reader.sv
// Directed bench for fb_stream_reader: a default instance (swap on, single shot)
// and a small continuous instance (swap off, 32-pixel image).
`timescale 1ns/1ps
module tb_fb_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        frame_sync;
  logic        fifo_wfull;
  logic        fifo_awfull;

  logic [12:0] fb_addr;
  logic [11:0] fb_data = 12'h000;
  logic        fifo_winc;
  logic [15:0] fifo_wdata;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frames_cnt;

  logic [12:0] fb_addr_c;
  logic [11:0] fb_data_c = 12'h000;
  logic        fifo_winc_c;
  logic [15:0] fifo_wdata_c;
  logic        busy_c;
  logic        frame_done_c;
  logic [7:0]  frames_cnt_c;

  int checks = 0;
  int errors = 0;

  logic [15:0] got   [0:32767];
  logic [15:0] got_c [0:255];
  int wr_cnt = 0;
  int wr_cnt_c = 0;
  int done_cnt = 0;
  int done_cnt_c = 0;
  int busy_fall_c = 0;
  int aw_viol = 0;
  logic        prev_awfull = 1'b0;
  logic [12:0] prev_addr = 13'd0;
  logic        prev_busy_c = 1'b0;

  always #5 clk = ~clk;

  fb_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_sync(frame_sync),
    .fb_addr(fb_addr), .fb_data(fb_data),
    .fifo_wfull(fifo_wfull), .fifo_awfull(fifo_awfull),
    .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata),
    .busy(busy), .frame_done(frame_done), .frames_cnt(frames_cnt)
  );

  fb_stream_reader #(.c_img_cols(8), .c_img_rows(4), .c_swap_r_b(1'b0), .c_continuous(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(1'b0), .frame_sync(frame_sync),
    .fb_addr(fb_addr_c), .fb_data(fb_data_c),
    .fifo_wfull(1'b0), .fifo_awfull(1'b0),
    .fifo_winc(fifo_winc_c), .fifo_wdata(fifo_wdata_c),
    .busy(busy_c), .frame_done(frame_done_c), .frames_cnt(frames_cnt_c)
  );

  function automatic logic [11:0] fbc_word(input logic [12:0] a);
    case (a)
      13'd0:   return 12'hF0A;
      13'd1:   return 12'hFFF;
      13'd2:   return 12'h000;
      default: return a[11:0];
    endcase
  endfunction

  // Expected pixel for address a with red/blue swapped output.
  function automatic logic [15:0] exp_px(input int a);
    logic [11:0] d;
    d = a[11:0];
    return {d[3:0], d[3], d[7:4], d[7:6], d[11:8], d[11]};
  endfunction

  // Frame buffer models: one-cycle read latency.
  always @(posedge clk) begin
    fb_data   <= fb_addr[11:0];
    fb_data_c <= fbc_word(fb_addr_c);
  end

  // FIFO-side monitors.
  always @(negedge clk) begin
    if (fifo_winc) begin
      got[wr_cnt[14:0]] <= fifo_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (fifo_winc_c) begin
      got_c[wr_cnt_c[7:0]] <= fifo_wdata_c;
      wr_cnt_c <= wr_cnt_c + 1;
    end
    if (frame_done)   done_cnt   <= done_cnt + 1;
    if (frame_done_c) done_cnt_c <= done_cnt_c + 1;
    if (prev_busy_c && !busy_c) busy_fall_c <= busy_fall_c + 1;
    prev_busy_c <= busy_c;
    if (prev_awfull && fb_addr != prev_addr) aw_viol <= aw_viol + 1;
    prev_awfull <= fifo_awfull;
    prev_addr   <= fb_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input int base);
    int bad;
    bad = -1;
    for (int i = 0; i < 4800; i++) begin
      if (bad < 0 && got[(base + i) % 32768] !== exp_px(i)) bad = i;
    end
    chk({tag, "_first_bad_index"}, bad, -1);
    chk({tag, "_write_count"}, wr_cnt - base, 4800);
  endtask

  // Pulse start and wait for frame_done; returns edges counted from the start edge.
  task automatic start_and_wait(output int edges);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    while (!frame_done && edges < 20000) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    int base;
    int edges;
    int k;
    int d0;
    rst_n = 1'b0; start = 1'b0; frame_sync = 1'b0; fifo_wfull = 1'b0; fifo_awfull = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_winc", fifo_winc, 0);
    chk("rst_wdata", fifo_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frames_cnt", frames_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Test 1/2: unstalled frame, timing, ordering and conversion values.
    base = wr_cnt;
    start_and_wait(edges);
    chk("t1_done_edge", edges, 4803);
    chk("t1_frames_cnt", frames_cnt, 1);
    chk_frame("t1", base);
    chk("t2_px_F0A", got[base + 3850], 16'hA81F);
    chk("t2_px_FFF", got[base + 4095], 16'hFFFF);
    chk("t2_px_000", got[base], 16'h0000);
    @(posedge clk); #1;
    chk("t1_done_pulse", frame_done, 0);
    chk("t1_busy_after", busy, 0);

    // Test 3: almost-full and full windows.
    base = wr_cnt;
    start = 1'b1;
    k = 0;
    do begin
      @(posedge clk); k++; #1;
      start = 1'b0;
      fifo_awfull = (k >= 99 && k <= 110);
      fifo_wfull  = (k >= 100 && k <= 109);
    end while (!frame_done && k < 20000);
    fifo_awfull = 1'b0; fifo_wfull = 1'b0;
    chk_frame("t3", base);
    chk("t3_no_issue_in_awfull", aw_viol, 0);
    chk("t3_frames_cnt", frames_cnt, 2);
    chk("t3_stall_extends", (k > 4803) ? 1 : 0, 1);

    @(posedge clk); #1;
    // Test 4: single-cycle full while a read is returning -> skid path.
    base = wr_cnt;
    start = 1'b1;
    k = 0;
    do begin
      @(posedge clk); k++; #1;
      start = 1'b0;
      fifo_wfull = (k == 50);
      if (k == 50) begin
        chk("t4_px47_winc", fifo_winc, 1);
        chk("t4_px47_data", fifo_wdata, 16'hF900);
      end
      if (k == 51) chk("t4_stall_winc", fifo_winc, 0);
      if (k == 52) begin
        chk("t4_skid_winc", fifo_winc, 1);
        chk("t4_skid_data", fifo_wdata, 16'h0180);
      end
      if (k == 53) chk("t4_next_data", fifo_wdata, 16'h1180);
    end while (!frame_done && k < 20000);
    fifo_wfull = 1'b0;
    chk_frame("t4", base);
    chk("t4_frames_cnt", frames_cnt, 3);

    @(posedge clk); #1;
    // Test 5a: start re-pulsed mid-frame is ignored.
    base = wr_cnt;
    d0 = done_cnt;
    start = 1'b1;
    for (int i = 1; i <= 5200; i++) begin
      @(posedge clk); #1;
      start = (fb_addr == 13'd1000);
    end
    start = 1'b0;
    chk("t5_single_done", done_cnt - d0, 1);
    chk("t5_write_count", wr_cnt - base, 4800);
    chk("t5_frames_cnt", frames_cnt, 4);
    chk("t5_busy_after", busy, 0);

    // Test 5b: continuous instance, two frame_sync edges -> two back-to-back frames.
    frame_sync = 1'b1;
    repeat (2) @(posedge clk); #1;
    frame_sync = 1'b0;
    repeat (8) @(posedge clk); #1;
    frame_sync = 1'b1;
    repeat (2) @(posedge clk); #1;
    frame_sync = 1'b0;
    repeat (200) @(posedge clk); #1;
    chk("t5c_frames_cnt", frames_cnt_c, 2);
    chk("t5c_done_pulses", done_cnt_c, 2);
    chk("t5c_write_count", wr_cnt_c, 64);
    chk("t5c_busy_gaps", busy_fall_c, 1);
    chk("t2_noswap_F0A", got_c[0], 16'hF815);
    chk("t2_noswap_FFF", got_c[1], 16'hFFFF);
    chk("t2_noswap_000", got_c[2], 16'h0000);
    chk("t5c_frame2_first", got_c[32], 16'hF815);
    chk("t5_sync_ignored_cnt", frames_cnt, 4);
    chk("t5_sync_ignored_busy", busy, 0);

    // Test 6: reset mid-frame at address 2000, then a clean frame.
    start = 1'b1;
    k = 0;
    do begin
      @(posedge clk); k++; #1;
      start = 1'b0;
    end while (fb_addr != 13'd2000 && k < 10000);
    chk("t6_reached_2000", fb_addr, 2000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_winc", fifo_winc, 0);
    chk("t6_rst_addr", fb_addr, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cnt", frames_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = wr_cnt;
    start_and_wait(edges);
    chk("t6_done_edge", edges, 4803);
    chk_frame("t6", base);
    chk("t6_frames_cnt", frames_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
